// File: rtl/sub_circuit_activity_monitor.sv
// Switching-activity monitor for a 4-in/1-out power benchmark sub-circuit.
// Optional static-probability counters: define ACTIVITY_ONES_COUNT_EN.
module sub_circuit_activity_monitor #(
   parameter int N_IN   = 4,
   parameter int CNT_W  = 16,
   parameter int WIN_W  = 16,
   parameter int RSEL_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIN_W-1:0]  win_len,
   input  logic [N_IN-1:0]   pi,
   input  logic              po,
   output logic              busy,
   output logic              done,
   input  logic [RSEL_W-1:0] rd_sel,
   output logic [CNT_W-1:0]  rd_data
);

   localparam int NSIG  = N_IN + 1;
   localparam int SUM_W = CNT_W + $clog2(NSIG + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      COUNT,
      DONE
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [WIN_W-1:0]   remaining;
   logic               done_nxt;
   logic               accept;

   logic [NSIG-1:0]    sig;
   logic [NSIG-1:0]    prev;
   logic [NSIG-1:0]    tog;
   logic [CNT_W-1:0]   cnt [NSIG];
   logic [CNT_W-1:0]   total;
   logic [SUM_W-1:0]   tog_sum;
   logic [SUM_W-1:0]   total_sum;

`ifdef ACTIVITY_ONES_COUNT_EN
   logic [CNT_W-1:0]   ones [NSIG];
`endif

   // po sits just above the primary inputs so index order matches rd_sel
   assign sig    = {po, pi};
   assign tog    = sig ^ prev;
   assign accept = (state == IDLE) && start;

   // State register, window length bookkeeping and registered done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
         done      <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
         if (accept) begin
            remaining <= win_len;
         end else if (state == COUNT) begin
            remaining <= remaining - WIN_W'(1);
         end
      end
   end

   // Next-state decode; done fires on the cycle after DONE is occupied
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = PRIME;
            end
         end
         PRIME: begin
            busy = 1'b1;
            if (remaining == '0) begin
               state_nxt = DONE;
            end else begin
               state_nxt = COUNT;
            end
         end
         COUNT: begin
            busy = 1'b1;
            if (remaining == WIN_W'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Number of signals that toggled on this edge, feeding the total
   always_comb begin
      tog_sum = '0;
      for (int i = 0; i < NSIG; i++) begin
         tog_sum = tog_sum + SUM_W'(tog[i]);
      end
      total_sum = SUM_W'(total) + tog_sum;
   end

   // Per-signal toggle counters, total and previous-sample registers
   always_ff @(posedge clk) begin
      if (rst || accept) begin
         for (int i = 0; i < NSIG; i++) begin
            cnt[i] <= '0;
         end
         total <= '0;
         if (rst) begin
            prev <= '0;
         end
      end else if (state == PRIME) begin
         prev <= sig;
      end else if (state == COUNT) begin
         prev <= sig;
         for (int i = 0; i < NSIG; i++) begin
            if (tog[i] && (cnt[i] != CNT_MAX)) begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
         if (total_sum > SUM_W'(CNT_MAX)) begin
            total <= CNT_MAX;
         end else begin
            total <= total_sum[CNT_W-1:0];
         end
      end
   end

`ifdef ACTIVITY_ONES_COUNT_EN
   // Static-probability counters: cycles spent at 1 during COUNT only
   always_ff @(posedge clk) begin
      if (rst || accept) begin
         for (int i = 0; i < NSIG; i++) begin
            ones[i] <= '0;
         end
      end else if (state == COUNT) begin
         for (int i = 0; i < NSIG; i++) begin
            if (sig[i] && (ones[i] != CNT_MAX)) begin
               ones[i] <= ones[i] + CNT_W'(1);
            end
         end
      end
   end
`endif

   // Read mux over the held counters; unmapped indices read zero
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NSIG; i++) begin
         if (rd_sel == RSEL_W'(i)) begin
            rd_data = cnt[i];
         end
      end
      if (rd_sel == RSEL_W'(NSIG)) begin
         rd_data = total;
      end
`ifdef ACTIVITY_ONES_COUNT_EN
      for (int i = 0; i < NSIG; i++) begin
         if (rd_sel == RSEL_W'(NSIG + 1 + i)) begin
            rd_data = ones[i];
         end
      end
`endif
   end

endmodule

// File: tb/tb_sub_circuit_activity_monitor.sv
// Self-checking bench for sub_circuit_activity_monitor (16-bit and 4-bit counters).
// Expected values come from a sample-sequence model; honours ACTIVITY_ONES_COUNT_EN.
`timescale 1ns/1ps
module tb_sub_circuit_activity_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] win_len;
   logic [3:0]  pi;
   logic        po;
   logic [3:0]  rd_sel;
   logic        busy;
   logic        done;
   logic [15:0] rd_data;
   logic        busy4;
   logic        done4;
   logic [3:0]  rd_data4;

   int checks   = 0;
   int failures = 0;

   // samples seen at PRIME then each COUNT edge, bit i = pi[i], bit 4 = po
   logic [4:0] samp [$];

   always #5 clk = ~clk;

   sub_circuit_activity_monitor dut (
      .clk(clk), .rst(rst), .start(start), .win_len(win_len),
      .pi(pi), .po(po), .busy(busy), .done(done),
      .rd_sel(rd_sel), .rd_data(rd_data)
   );

   sub_circuit_activity_monitor #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .win_len(win_len),
      .pi(pi), .po(po), .busy(busy4), .done(done4),
      .rd_sel(rd_sel), .rd_data(rd_data4)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   // Expected reading at rd_sel for counters saturating at maxv
   function automatic int exp_val(input int sel, input int maxv);
      int t [5];
      int o [5];
      int sum;
      sum = 0;
      for (int s = 0; s < 5; s++) begin
         t[s] = 0;
         o[s] = 0;
      end
      for (int k = 1; k < samp.size(); k++) begin
         for (int s = 0; s < 5; s++) begin
            if (samp[k][s] != samp[k-1][s]) begin
               t[s]++;
               sum++;
            end
            if (samp[k][s]) o[s]++;
         end
      end
      if (sel < 5) return sat(t[sel], maxv);
      if (sel == 5) return sat(sum, maxv);
`ifdef ACTIVITY_ONES_COUNT_EN
      if (sel <= 10) return sat(o[sel-6], maxv);
`endif
      return 0;
   endfunction

   task automatic check_all(input string tag);
      for (int s = 0; s < 16; s++) begin
         rd_sel = 4'(s);
         #0.2;
         chk($sformatf("%s_w16_sel%0d", tag, s), 32'(rd_data),
             32'(exp_val(s, 65535)));
         chk($sformatf("%s_w4_sel%0d", tag, s), 32'(rd_data4),
             32'(exp_val(s, 15)));
      end
   endtask

   task automatic drive(input int mode, input int k);
      case (mode)
         0: begin pi = 4'b1010; po = 1'b1; end
         1: begin pi = 4'(k % 2); po = 1'b0; end
         2: begin pi = 4'((k % 2) * 2); po = 1'b0; end
         4: begin pi = 4'b0000; po = (k >= 1 && k <= 4); end
         default: begin pi = 4'($urandom); po = 1'($urandom); end
      endcase
   endtask

   // Accept a window, feed win+1 samples, check done timing and count
   task automatic run_window(input string tag, input int win,
                             input int mode, input bit hold_start);
      int done_at;
      int done_cnt;
      done_at  = -1;
      done_cnt = 0;
      samp.delete();
      start   = 1'b1;
      win_len = 16'(win);
      step();
      start = 1'b0;
      chk({tag, "_busy_prime"}, 32'(busy), 32'd1);
      chk({tag, "_busy4_prime"}, 32'(busy4), 32'd1);
      for (int k = 0; k <= win + 3; k++) begin
         if (k <= win) begin
            drive(mode, k);
            samp.push_back({po, pi});
         end
         start = hold_start && (k >= 2) && (k <= 4) && (k < win);
         step();
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = k + 1;
         end
      end
      start = 1'b0;
      chk({tag, "_done_latency"}, 32'(done_at), 32'(win + 2));
      chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int nd;
      rst     = 1'b1;
      start   = 1'b0;
      win_len = '0;
      pi      = '0;
      po      = 1'b0;
      rd_sel  = '0;
      step();
      step();
      rst = 1'b0;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      samp.delete();
      check_all("reset");

      // reset wins over a simultaneous start
      rst     = 1'b1;
      start   = 1'b1;
      win_len = 16'd5;
      step();
      rst   = 1'b0;
      start = 1'b0;
      chk("rst_vs_start_busy", 32'(busy), 32'd0);
      step();
      chk("rst_vs_start_busy2", 32'(busy), 32'd0);

      run_window("const", 8, 0, 1'b0);
      check_all("const");

      run_window("tog0", 10, 1, 1'b0);
      check_all("tog0");
      rd_sel = 4'd0;
      #0.2;
      chk("tog0_direct_sel0", 32'(rd_data), 32'd10);
      rd_sel = 4'd5;
      #0.2;
      chk("tog0_direct_total", 32'(rd_data), 32'd10);

      run_window("sat", 20, 2, 1'b0);
      check_all("sat");
      rd_sel = 4'd1;
      #0.2;
      chk("sat_direct_w4_sel1", 32'(rd_data4), 32'd15);
      chk("sat_direct_w16_sel1", 32'(rd_data), 32'd20);

      run_window("win0", 0, 3, 1'b0);
      check_all("win0");

      run_window("holdstart", 6, 3, 1'b1);
      check_all("holdstart");

      // reset in the middle of a window
      start   = 1'b1;
      win_len = 16'd10;
      step();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(3, k);
         step();
      end
      drive(3, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      nd = 0;
      for (int k = 0; k < 14; k++) begin
         step();
         if (done) nd++;
      end
      chk("midrst_no_done", 32'(nd), 32'd0);
      samp.delete();
      check_all("midrst");

      run_window("after_rst", 9, 3, 1'b0);
      check_all("after_rst");

      run_window("ones", 8, 4, 1'b0);
      check_all("ones");
      rd_sel = 4'd10;
      #0.2;
`ifdef ACTIVITY_ONES_COUNT_EN
      chk("ones_direct_po", 32'(rd_data), 32'd4);
`else
      chk("ones_direct_po", 32'(rd_data), 32'd0);
`endif

      for (int r = 0; r < 6; r++) begin
         run_window($sformatf("rand%0d", r), $urandom_range(1, 25), 3, 1'b0);
         check_all($sformatf("rand%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
